motor_bridge_guard: RTL
=======================

Name: motor_bridge_guard

Overview:
- Parametrised successor to the single-bridge current sensor block.
- Drives NUM_MOTORS H-bridge input pairs from per-channel direction commands.
- Adds per-channel overcurrent filtering, timed auto-retry, fault latching and direction-reversal dead-time.
- Sits between the switch/command logic and the H-bridge pins (IN bus) on the motor board.

Parameters:
- NUM_MOTORS, 2, number of independent bridge channels.
- OC_FILTER, 4, consecutive synchronised oc-high cycles required to trip.
- RETRY_CYCLES, 16, cycles outputs held off after a trip; also the clean-run window that clears the retry count.
- MAX_RETRIES, 3, trips tolerated with auto-retry before the channel latches.
- DEADTIME, 8, coast cycles inserted on forward<->reverse reversal.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- cmd  input  2*NUM_MOTORS  per-channel command, channel n at [2n+1:2n]: 00 coast, 01 forward, 10 reverse, 11 brake.
- oc  input  NUM_MOTORS  asynchronous overcurrent comparator flags.
- fault_clr  input  1  synchronous pulse that clears latched channels.
- IN  output  2*NUM_MOTORS  bridge inputs, channel n at [2n+1:2n]: forward 10, reverse 01, brake 11, coast 00.
- tripped  output  NUM_MOTORS  channel is in TRIP hold-off.
- latched  output  NUM_MOTORS  channel is in LATCH.

Behaviour:
- One clock domain; reset is asynchronous and active-low.
- Reset values: IN=0, tripped=0, latched=0; all counters and synchronisers 0; every FSM in RUN.
- oc passes through a 2-flop synchroniser per channel. The filter counter increments while the synchronised flag is high and clears to 0 when it is low.
- Trip timing: the trip registers on the edge that samples the OC_FILTER-th consecutive high synchronised value. If edge 1 is the first edge oc is high at, IN=00 and tripped=1 from edge OC_FILTER+2 (edge 6 with defaults).
- IN is registered: a cmd change in RUN appears on IN one cycle later.
- Per-channel FSM states: RUN, DEAD, TRIP, LATCH.
  - RUN: IN is the encoding of cmd. On a forward<->reverse change (01->10 or 10->01), go to DEAD with IN=00. Changes to or from coast or brake apply immediately.
  - DEAD: IN=00 for DEADTIME cycles, then RUN with the current cmd. A cmd change during DEAD does not restart the timer.
  - TRIP: IN=00 for RETRY_CYCLES cycles, then RUN with the current cmd. The filter counter is held at 0 during TRIP.
  - LATCH: IN=00, latched=1. Exits to RUN only when fault_clr=1 and that channel's cmd=00 in the same cycle; otherwise fault_clr is ignored.
- Retry counter (0..MAX_RETRIES) per channel:
  - On each trip decision, if count<MAX_RETRIES: increment and go to TRIP; else go to LATCH.
  - Clears to 0 after RETRY_CYCLES consecutive RUN cycles with synchronised oc low.
- Precedence: a trip decision overrides a DEAD entry or exit in the same cycle. reset overrides everything, including mid-TRIP and mid-DEAD.
- fault_clr while a channel is not latched: no effect on that channel.
- Channels are fully independent; a trip on channel n never alters channel m.
- Counter widths use $clog2(max+1) of their respective parameter.

Optional Feature:
- Macro: BRAKE_ON_TRIP_EN.
- Defined: in TRIP, IN=11 (brake) instead of 00. DEAD and LATCH still drive 00.
- Undefined: TRIP drives 00 (coast).

Decomposition:
- Shared package motor_pkg holds:
  - command encodings CMD_COAST, CMD_FWD, CMD_REV, CMD_BRAKE;
  - bridge encodings BR_COAST, BR_FWD, BR_REV, BR_BRAKE;
  - the FSM state typedef (RUN, DEAD, TRIP, LATCH).
- One sub-module, motor_channel_guard, implements a single channel: synchroniser, filter, retry counter and FSM.
- The top generates NUM_MOTORS instances and shares fault_clr across them.

Test Plan:
- Release reset, cmd ch0=01 -> IN[1:0]=10 one cycle later; ch1 stays 00; tripped=latched=0.
- ch0 01 running, cmd changes to 10 -> IN[1:0]=00 for exactly 8 cycles, then 01. A 01->11 change -> IN=11 next cycle with no dead-time.
- oc[0] high 3 edges then low -> no trip. oc[0] high 4+ edges -> IN[1:0]=00 and tripped[0]=1 at edge 6; held 16 cycles, then IN=10 again (cmd=01).
- Four trips with no 16-cycle clean window between them -> trips 1-3 retry, trip 4 sets latched[0]=1 with IN=00. fault_clr with cmd=01 -> stays latched; fault_clr with cmd=00 -> latched=0, RUN.
- Drive reset low mid-TRIP on ch1 -> IN, tripped and latched all 0 immediately (asynchronous); ch1 resumes normally after release.
- With BRAKE_ON_TRIP_EN defined, repeat the trip scenario -> IN[1:0]=11 during the 16-cycle hold-off.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared definitions for the motor bridge guard.
//   - command encodings on cmd (CMD_*)
//   - H-bridge pin encodings on IN (BR_*)
//   - per-channel guard FSM state type
//   - helpers that map a command onto the bridge pins and spot a reversal
package motor_pkg;

    localparam logic [1:0] CMD_COAST = 2'b00;
    localparam logic [1:0] CMD_FWD   = 2'b01;
    localparam logic [1:0] CMD_REV   = 2'b10;
    localparam logic [1:0] CMD_BRAKE = 2'b11;

    localparam logic [1:0] BR_COAST  = 2'b00;
    localparam logic [1:0] BR_FWD    = 2'b10;
    localparam logic [1:0] BR_REV    = 2'b01;
    localparam logic [1:0] BR_BRAKE  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DEAD  = 2'd1,
        ST_TRIP  = 2'd2,
        ST_LATCH = 2'd3
    } guard_state_t;

    function automatic logic [1:0] cmd_to_bridge(input logic [1:0] cmd);
        logic [1:0] drive;
        case (cmd)
            CMD_FWD:   drive = BR_FWD;
            CMD_REV:   drive = BR_REV;
            CMD_BRAKE: drive = BR_BRAKE;
            default:   drive = BR_COAST;
        endcase
        return drive;
    endfunction

    // True when the bridge is currently driving one direction and the new
    // command asks for the opposite one.
    function automatic logic is_reversal(input logic [1:0] drive, input logic [1:0] cmd);
        return ((drive == BR_FWD) && (cmd == CMD_REV)) ||
               ((drive == BR_REV) && (cmd == CMD_FWD));
    endfunction

endpackage

// File: rtl/motor_bridge_guard_if.sv
// Command/status bundle between the switch/command logic and the bridge guard.
//   cmd       per-channel command, channel n at [2n+1:2n]
//   oc        asynchronous overcurrent comparator flags
//   fault_clr synchronous clear pulse for latched channels
//   IN        H-bridge input pins, channel n at [2n+1:2n]
//   tripped   channel is in retry hold-off
//   latched   channel is latched off
// master: command side, slave: the guard.
interface motor_bridge_guard_if #(
    parameter int NUM_MOTORS = 2
);
    logic [2*NUM_MOTORS-1:0] cmd;
    logic [NUM_MOTORS-1:0]   oc;
    logic                    fault_clr;
    logic [2*NUM_MOTORS-1:0] IN;
    logic [NUM_MOTORS-1:0]   tripped;
    logic [NUM_MOTORS-1:0]   latched;

    modport master (
        output cmd, oc, fault_clr,
        input  IN, tripped, latched
    );

    modport slave (
        input  cmd, oc, fault_clr,
        output IN, tripped, latched
    );
endinterface

// File: rtl/motor_channel_guard.sv
// One H-bridge channel: oc synchroniser, overcurrent filter, retry counter
// and the guard FSM that drives the two bridge pins.
// Ports:
//   clk, reset    system clock, asynchronous active-low reset
//   cmd_i         2-bit command (coast/fwd/rev/brake)
//   oc_i          raw asynchronous overcurrent flag
//   fault_clr_i   clear request for a latched channel
//   in_o          registered bridge pin drive
//   tripped_o     registered, high while in retry hold-off
//   latched_o     registered, high while latched off
// Build option: BRAKE_ON_TRIP_EN makes the hold-off drive brake instead of coast.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | bridge follows cmd
// ST_DEAD  | coast for DEADTIME cycles on a fwd<->rev reversal
// ST_TRIP  | overcurrent hold-off for RETRY_CYCLES cycles, then retry
// ST_LATCH | retries exhausted; coast until fault_clr with cmd = coast
module motor_channel_guard
    import motor_pkg::*;
#(
    parameter int OC_FILTER    = 4,
    parameter int RETRY_CYCLES = 16,
    parameter int MAX_RETRIES  = 3,
    parameter int DEADTIME     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] cmd_i,
    input  logic       oc_i,
    input  logic       fault_clr_i,
    output logic [1:0] in_o,
    output logic       tripped_o,
    output logic       latched_o
);

    localparam int FILT_W  = $clog2(OC_FILTER + 1);
    localparam int HOLD_W  = $clog2(RETRY_CYCLES + 1);
    localparam int DEAD_W  = $clog2(DEADTIME + 1);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

`ifdef BRAKE_ON_TRIP_EN
    localparam logic [1:0] TRIP_DRIVE = BR_BRAKE;
`else
    localparam logic [1:0] TRIP_DRIVE = BR_COAST;
`endif

    guard_state_t         state_q;
    logic [1:0]           in_q;
    logic                 tripped_q;
    logic                 latched_q;
    logic [DEAD_W-1:0]    dead_tmr_q;
    logic [HOLD_W-1:0]    trip_tmr_q;
    logic                 sync1_q;
    logic                 sync2_q;
    logic [FILT_W-1:0]    filt_q;
    logic [HOLD_W-1:0]    clean_q;
    logic [RETRY_W-1:0]   retry_q;

    logic trip_hit;
    logic clean_cycle;

    // The edge that sees the OC_FILTER-th consecutive high sample trips.
    assign trip_hit    = sync2_q && (filt_q >= FILT_W'(OC_FILTER - 1)) &&
                         ((state_q == ST_RUN) || (state_q == ST_DEAD));
    assign clean_cycle = (state_q == ST_RUN) && !sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= '0;
            clean_q <= '0;
            retry_q <= '0;
        end else begin
            sync1_q <= oc_i;
            sync2_q <= sync1_q;

            if ((state_q == ST_TRIP) || !sync2_q) begin
                filt_q <= '0;
            end else if (filt_q != FILT_W'(OC_FILTER)) begin
                filt_q <= filt_q + 1'b1;
            end

            if (!clean_cycle) begin
                clean_q <= '0;
            end else if (clean_q != HOLD_W'(RETRY_CYCLES)) begin
                clean_q <= clean_q + 1'b1;
            end

            if (trip_hit && (retry_q != RETRY_W'(MAX_RETRIES))) begin
                retry_q <= retry_q + 1'b1;
            end else if (clean_cycle && (clean_q == HOLD_W'(RETRY_CYCLES - 1))) begin
                retry_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            in_q       <= BR_COAST;
            tripped_q  <= 1'b0;
            latched_q  <= 1'b0;
            dead_tmr_q <= '0;
            trip_tmr_q <= '0;
        end else if (trip_hit) begin
            // A trip wins over any DEAD entry or exit on the same edge.
            if (retry_q != RETRY_W'(MAX_RETRIES)) begin
                state_q    <= ST_TRIP;
                in_q       <= TRIP_DRIVE;
                tripped_q  <= 1'b1;
                trip_tmr_q <= HOLD_W'(RETRY_CYCLES - 1);
            end else begin
                state_q   <= ST_LATCH;
                in_q      <= BR_COAST;
                latched_q <= 1'b1;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (is_reversal(in_q, cmd_i)) begin
                        state_q    <= ST_DEAD;
                        in_q       <= BR_COAST;
                        dead_tmr_q <= DEAD_W'(DEADTIME - 1);
                    end else begin
                        in_q <= cmd_to_bridge(cmd_i);
                    end
                end
                ST_DEAD: begin
                    if (dead_tmr_q == '0) begin
                        state_q <= ST_RUN;
                        in_q    <= cmd_to_bridge(cmd_i);
                    end else begin
                        dead_tmr_q <= dead_tmr_q - 1'b1;
                    end
                end
                ST_TRIP: begin
                    if (trip_tmr_q == '0) begin
                        state_q   <= ST_RUN;
                        in_q      <= cmd_to_bridge(cmd_i);
                        tripped_q <= 1'b0;
                    end else begin
                        trip_tmr_q <= trip_tmr_q - 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (fault_clr_i && (cmd_i == CMD_COAST)) begin
                        state_q   <= ST_RUN;
                        in_q      <= BR_COAST;
                        latched_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    in_q    <= BR_COAST;
                end
            endcase
        end
    end

    assign in_o      = in_q;
    assign tripped_o = tripped_q;
    assign latched_o = latched_q;

endmodule

// File: rtl/motor_bridge_guard.sv
// Multi-channel H-bridge guard: one motor_channel_guard per bridge, all
// sharing clk, reset and fault_clr; channels are otherwise independent.
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   bus    slave side of motor_bridge_guard_if (cmd/oc/fault_clr in,
//          IN/tripped/latched out)
// Build option: BRAKE_ON_TRIP_EN (see motor_channel_guard).
module motor_bridge_guard
    import motor_pkg::*;
#(
    parameter int NUM_MOTORS   = 2,
    parameter int OC_FILTER    = 4,
    parameter int RETRY_CYCLES = 16,
    parameter int MAX_RETRIES  = 3,
    parameter int DEADTIME     = 8
) (
    input  logic                clk,
    input  logic                reset,
    motor_bridge_guard_if.slave bus
);

    for (genvar n = 0; n < NUM_MOTORS; n++) begin : g_ch
        motor_channel_guard #(
            .OC_FILTER   (OC_FILTER),
            .RETRY_CYCLES(RETRY_CYCLES),
            .MAX_RETRIES (MAX_RETRIES),
            .DEADTIME    (DEADTIME)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .cmd_i      (bus.cmd[2*n +: 2]),
            .oc_i       (bus.oc[n]),
            .fault_clr_i(bus.fault_clr),
            .in_o       (bus.IN[2*n +: 2]),
            .tripped_o  (bus.tripped[n]),
            .latched_o  (bus.latched[n])
        );
    end

endmodule
